tap_mode_ctrl: RTL and testbench

Controller that sequences run-time changes of the Mega Drive controller-port adapter configuration (Team Player port selection, 4-Way Play enable) requested from the OSD. It debounces the requested mode, waits for a quiet window with no CPU access to the port 1/2 data or control registers, and holds the adapter protocol engines in reset. Only then does it commit the new enables. It sits between the OSD/config registers and the multitap wrapper, driving that wrapper's TEAMPLAYER_EN/FOURWAY_EN inputs and a protocol reset.

---
 rtl/tap_mode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tap_mode_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tap_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tap_mode_ctrl : sequences OSD-requested multitap mode changes safely
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tap_mode_ctrl #(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned QUIET_CYC  = 1024,
  parameter int unsigned MAX_WAIT   = 65535,
  parameter int unsigned RST_CYC    = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic [1:0] REQ_TP,
  input  logic       REQ_FW,
  input  logic       SEL,
  input  logic [3:0] A,
  output logic [1:0] TEAMPLAYER_EN,
  output logic       FOURWAY_EN,
  output logic       PORT_RST,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STABLE = 3'd1,
    S_QUIET  = 3'd2,
    S_SWITCH = 3'd3,
    S_APPLY  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cur_q, cur_d;
  logic [2:0]  tgt_q, tgt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic [1:0]  tp_en_q;
  logic        fw_en_q;
  logic        prst_q;
  logic        busy_q;

  logic [2:0]  req_n;
  logic        port_acc;
  logic [31:0] cnt_p1, qcnt_p1;
  logic [15:0] cnt_sat, qcnt_sat;

  // 4-Way Play excludes Team Player; dual Team Player collapses to port 1
  always_comb begin
    if (REQ_FW) req_n = 3'b100;
    else if (REQ_TP == 2'b11) req_n = 3'b001;
    else req_n = {1'b0, REQ_TP};
  end

  assign port_acc = SEL && ((A == 4'd1) || (A == 4'd2) || (A == 4'd4) || (A == 4'd5));

  // Compares against count+1 so limits of 0 and 1 both mean a single tick
  assign cnt_p1   = {16'd0, cnt_q} + 32'd1;
  assign qcnt_p1  = {16'd0, qcnt_q} + 32'd1;
  assign cnt_sat  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign qcnt_sat = (qcnt_q == 16'hFFFF) ? qcnt_q : qcnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_n != cur_q) begin
          tgt_d   = req_n;
          cnt_d   = 16'd0;
          state_d = S_STABLE;
        end
      end
      S_STABLE: begin
        if (req_n == cur_q) begin
          state_d = S_IDLE;
        end else if (req_n != tgt_q) begin
          tgt_d = req_n;
          cnt_d = 16'd0;
        end else if (CE) begin
          if (cnt_p1 >= STABLE_CYC) begin
            cnt_d   = 16'd0;
            qcnt_d  = 16'd0;
            state_d = S_QUIET;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end
      S_QUIET: begin
        if (req_n == cur_q) begin
          state_d = S_IDLE;
        end else if (req_n != tgt_q) begin
          tgt_d   = req_n;
          cnt_d   = 16'd0;
          state_d = S_STABLE;
        end else begin
          if (port_acc) qcnt_d = 16'd0;
          // A port access vetoes quiet expiry but never the forced timeout
          if (CE) begin
            if ((cnt_p1 >= MAX_WAIT) || (!port_acc && (qcnt_p1 >= QUIET_CYC))) begin
              cnt_d   = 16'd0;
              state_d = S_SWITCH;
            end else begin
              cnt_d = cnt_sat;
              if (!port_acc) qcnt_d = qcnt_sat;
            end
          end
        end
      end
      S_SWITCH: begin
        if (CE) begin
          if (cnt_p1 >= RST_CYC) state_d = S_APPLY;
          else cnt_d = cnt_sat;
        end
      end
      S_APPLY: begin
        cur_d   = tgt_q;
        cnt_d   = 16'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cur_q   <= 3'd0;
      tgt_q   <= 3'd0;
      cnt_q   <= 16'd0;
      qcnt_q  <= 16'd0;
      tp_en_q <= 2'b00;
      fw_en_q <= 1'b0;
      prst_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      qcnt_q  <= qcnt_d;
      tp_en_q <= (state_d == S_SWITCH) ? 2'b00 : cur_d[1:0];
      fw_en_q <= (state_d == S_SWITCH) ? 1'b0 : cur_d[2];
      prst_q  <= (state_d == S_SWITCH);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign TEAMPLAYER_EN = tp_en_q;
  assign FOURWAY_EN    = fw_en_q;
  assign PORT_RST      = prst_q;
  assign BUSY          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tap_mode_ctrl.sv
// Directed bench for tap_mode_ctrl using the default parameter set.
`default_nettype none

module tb_tap_mode_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CE;
  logic [1:0] REQ_TP;
  logic       REQ_FW;
  logic       SEL;
  logic [3:0] A;
  logic [1:0] TEAMPLAYER_EN;
  logic       FOURWAY_EN;
  logic       PORT_RST;
  logic       BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  tap_mode_ctrl dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .CE            (CE),
    .REQ_TP        (REQ_TP),
    .REQ_FW        (REQ_FW),
    .SEL           (SEL),
    .A             (A),
    .TEAMPLAYER_EN (TEAMPLAYER_EN),
    .FOURWAY_EN    (FOURWAY_EN),
    .PORT_RST      (PORT_RST),
    .BUSY          (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] tp;
    logic       fw;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [2:0] en3();
    return {FOURWAY_EN, TEAMPLAYER_EN};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Nominal uninterrupted switch: 16 + 1024 + 4 + 2 edges after the request
  task automatic run_seq(input string nm, input logic [2:0] old_en, input logic [2:0] new_en);
    for (int n = 1; n <= 1046; n++) begin
      step();
      if (n == 1)    chk({nm, " busy_rise"}, BUSY, 1);
      if (n == 1040) chk({nm, " prst_pre"}, PORT_RST, 0);
      if (n == 1040) chk({nm, " en_pre"}, en3(), old_en);
      if (n == 1041) chk({nm, " prst_on"}, PORT_RST, 1);
      if (n == 1041) chk({nm, " en_sw"}, en3(), 0);
      if (n == 1044) chk({nm, " prst_last"}, PORT_RST, 1);
      if (n == 1045) chk({nm, " prst_off"}, PORT_RST, 0);
      if (n == 1045) chk({nm, " en_apply"}, en3(), old_en);
      if (n == 1046) chk({nm, " en_new"}, en3(), new_en);
      if (n == 1046) chk({nm, " busy_fall"}, BUSY, 0);
    end
  endtask

  initial begin
    logic prst_seen;
    logic [2:0] prev;

    tbl[0] = '{tp: 2'b10, fw: 1'b1, exp: 3'b100};
    tbl[1] = '{tp: 2'b11, fw: 1'b0, exp: 3'b001};
    tbl[2] = '{tp: 2'b10, fw: 1'b0, exp: 3'b010};
    tbl[3] = '{tp: 2'b11, fw: 1'b1, exp: 3'b100};
    tbl[4] = '{tp: 2'b00, fw: 1'b0, exp: 3'b000};

    RESET_N = 1'b0; CE = 1'b1; REQ_TP = 2'b00; REQ_FW = 1'b0; SEL = 1'b0; A = 4'd0;
    repeat (3) step();
    chk("rst_en", en3(), 0);
    chk("rst_prst", PORT_RST, 0);
    chk("rst_busy", BUSY, 0);

    // Basic Team Player on port 1
    RESET_N = 1'b1; REQ_TP = 2'b01;
    run_seq("basic", 3'b000, 3'b001);

    // Table of normalised requests, each differing from the previous commit
    prev = 3'b001;
    for (int i = 0; i < 5; i++) begin
      REQ_TP = tbl[i].tp; REQ_FW = tbl[i].fw;
      run_seq($sformatf("vec%0d", i), prev, tbl[i].exp);
      prev = tbl[i].exp;
    end

    // Short glitch: aborted without touching the adapter
    REQ_TP = 2'b01; REQ_FW = 1'b0;
    prst_seen = 1'b0;
    for (int n = 1; n <= 106; n++) begin
      if (n == 6) REQ_TP = 2'b00;
      step();
      if (PORT_RST) prst_seen = 1'b1;
      if (n == 1) chk("glitch busy_rise", BUSY, 1);
      if (n == 6) chk("glitch busy_fall", BUSY, 0);
    end
    chk("glitch prst", prst_seen, 0);
    chk("glitch en", en3(), 0);

    // Serial register hammered every tick is not a port access
    SEL = 1'b1; A = 4'd8; REQ_TP = 2'b10;
    run_seq("serial", 3'b000, 3'b010);
    SEL = 1'b0; A = 4'd0;

    // Access on the quiet-expiry edge restarts the quiet window
    REQ_TP = 2'b01;
    for (int n = 1; n <= 2070; n++) begin
      SEL = (n == 1041); A = (n == 1041) ? 4'd2 : 4'd0;
      step();
      if (n == 1041) chk("qwin prst_blocked", PORT_RST, 0);
      if (n == 2064) chk("qwin prst_pre", PORT_RST, 0);
      if (n == 2065) chk("qwin prst_on", PORT_RST, 1);
      if (n == 2070) chk("qwin en_new", en3(), 3'b001);
    end
    SEL = 1'b0; A = 4'd0;

    // Periodic accesses starve the quiet window; MAX_WAIT forces the switch
    REQ_TP = 2'b00;
    prst_seen = 1'b0;
    for (int n = 1; n <= 65557; n++) begin
      SEL = (n >= 18) && ((((n - 17) % 500) == 0) || (n == 65552));
      A = SEL ? 4'd1 : 4'd0;
      step();
      if (n < 65552 && PORT_RST) prst_seen = 1'b1;
      if (n == 65551) chk("force busy_hold", BUSY, 1);
      if (n == 65552) chk("force prst_on", PORT_RST, 1);
      if (n == 65557) chk("force en_new", en3(), 3'b000);
      if (n == 65557) chk("force busy_fall", BUSY, 0);
    end
    chk("force prst_early", prst_seen, 0);
    SEL = 1'b0; A = 4'd0;

    // Asynchronous reset while the adapter is held in reset
    REQ_TP = 2'b01;
    for (int n = 1; n <= 1042; n++) step();
    chk("arst prst_before", PORT_RST, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst prst", PORT_RST, 0);
    chk("arst en", en3(), 0);
    chk("arst busy", BUSY, 0);
    step();
    RESET_N = 1'b1;
    run_seq("replay", 3'b000, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
